// File: rtl/vec_pkg.sv
// Shared types and constants for the 1:16 vector demux (FSM state, destination count, select width).
package vec_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam int NUM_DST = 16;
  localparam int SEL_W   = 4;

  function automatic logic [NUM_DST-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_DST'(1) << sel;
  endfunction

endpackage

// File: rtl/vec_lane_counter.sv
// Lane counter for the serial vector write: counts 0..M-1, flags the last lane.
module vec_lane_counter #(
  parameter int M  = 16,
  parameter int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(M - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vec_demux_1_16.sv
// 1:16 vector demux: captures one vector write and applies it one lane per cycle into a
// 16-entry register array. Define VEC_DEMUX_BCAST_EN to add the in_bcast broadcast input.
module vec_demux_1_16
  import vec_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [M-1:0][N-1:0]               in_data,
  input  logic [SEL_W-1:0]                  in_sel,
  input  logic [M-1:0]                      in_mask,
`ifdef VEC_DEMUX_BCAST_EN
  input  logic                              in_bcast,
`endif
  output logic [NUM_DST-1:0][M-1:0][N-1:0]  out_reg,
  output logic [NUM_DST-1:0]                out_done,
  output logic                              busy
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  state_t               state, state_nxt;
  logic [M-1:0][N-1:0]  hold_data;
  logic [SEL_W-1:0]     hold_sel;
  logic [M-1:0]         hold_mask;
  logic [CW-1:0]        lane;
  logic                 last_lane;
  logic                 xfer;
  logic [NUM_DST-1:0]   dst_hit;

  assign xfer = in_valid && (state == ST_IDLE);

  vec_lane_counter #(.M(M), .CW(CW)) u_lane_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer || ((state == ST_WRITE) && last_lane)),
    .en    (state == ST_WRITE),
    .cnt   (lane),
    .tc    (last_lane)
  );

`ifdef VEC_DEMUX_BCAST_EN
  logic hold_bcast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_bcast <= 1'b0;
    end else if (xfer) begin
      hold_bcast <= in_bcast;
    end
  end

  assign dst_hit = hold_bcast ? '1 : sel_onehot(hold_sel);
`else
  assign dst_hit = sel_onehot(hold_sel);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_nxt = ST_WRITE;
      ST_WRITE: if (last_lane) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_WRITE);
    out_done = ((state == ST_WRITE) && last_lane) ? dst_hit : '0;
  end

  // Holding registers are loaded only on a transfer, so input changes while busy are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_sel  <= '0;
      hold_mask <= '0;
    end else if (xfer) begin
      hold_data <= in_data;
      hold_sel  <= in_sel;
      hold_mask <= in_mask;
    end
  end

  // NOTE: the register array is reset explicitly because an aborted write must leave no lanes behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if ((state == ST_WRITE) && hold_mask[lane]) begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (dst_hit[d]) begin
          out_reg[d][lane] <= hold_data[lane];
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_demux_1_16.sv
// Self-checking bench for vec_demux_1_16: directed cases plus random traffic against a lane-timing model.
// Broadcast cases are compiled in when VEC_DEMUX_BCAST_EN is defined.
module tb_vec_demux_1_16;

  localparam int N = 16;
  localparam int M = 16;
  localparam int D = 16;
  localparam int W = M * N;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [M-1:0][N-1:0]        in_data = '0;
  logic [3:0]                 in_sel = '0;
  logic [M-1:0]               in_mask = '0;
`ifdef VEC_DEMUX_BCAST_EN
  logic                       in_bcast = 1'b0;
`endif
  logic [D-1:0][M-1:0][N-1:0] out_reg;
  logic [D-1:0]               out_done;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_demux_1_16 #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_mask  (in_mask),
`ifdef VEC_DEMUX_BCAST_EN
    .in_bcast (in_bcast),
`endif
    .out_reg  (out_reg),
    .out_done (out_done),
    .busy     (busy)
  );

  // Reference model: committed register contents plus one pending write described by
  // its captured inputs and the number of clock edges elapsed since it was accepted.
  logic [N-1:0] mreg [D][M];
  bit           pend;
  int           elapsed;
  int           p_sel;
  logic [N-1:0] p_data [M];
  bit           p_mask [M];
  bit           p_bc;

  function automatic bit hits(int d);
    return p_bc || (d == p_sel);
  endfunction

  function automatic logic [W-1:0] exp_reg(int d);
    logic [W-1:0] r;
    for (int l = 0; l < M; l++) begin
      if (pend && hits(d) && (l < elapsed) && p_mask[l]) r[l*N +: N] = p_data[l];
      else                                               r[l*N +: N] = mreg[d][l];
    end
    return r;
  endfunction

  function automatic logic [D-1:0] exp_done();
    logic [D-1:0] r;
    r = '0;
    if (pend && (elapsed == M - 1))
      for (int d = 0; d < D; d++) if (hits(d)) r[d] = 1'b1;
    return r;
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int d = 0; d < D; d++) check($sformatf("%s_reg%0d", tag, d), W'(out_reg[d]), exp_reg(d));
    check({tag, "_busy"},  W'(busy),     W'(pend));
    check({tag, "_ready"}, W'(in_ready), W'(!pend));
    check({tag, "_done"},  W'(out_done), W'(exp_done()));
  endtask

  // One clock: the model decides acceptance from its own idle state, then checks at the falling edge.
  task automatic step(string tag);
    bit take;
    take = in_valid && !pend;
    if (take) begin
      p_sel = int'(in_sel);
      for (int l = 0; l < M; l++) begin
        p_data[l] = in_data[l];
        p_mask[l] = in_mask[l];
      end
`ifdef VEC_DEMUX_BCAST_EN
      p_bc = in_bcast;
`else
      p_bc = 1'b0;
`endif
    end
    @(posedge clk);
    if (take) begin
      pend    = 1'b1;
      elapsed = 0;
    end else if (pend) begin
      elapsed++;
    end
    @(negedge clk);
    if (pend && (elapsed == M)) begin
      for (int d = 0; d < D; d++)
        if (hits(d))
          for (int l = 0; l < M; l++) if (p_mask[l]) mreg[d][l] = p_data[l];
      pend = 1'b0;
    end
    check_all(tag);
  endtask

  // Asynchronous reset applied between clock edges; everything must clear immediately.
  task automatic do_reset(string tag);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    pend = 1'b0;
    for (int d = 0; d < D; d++) for (int l = 0; l < M; l++) mreg[d][l] = '0;
    check_all({tag, "_in"});
    #1 rst_n = 1'b1;
    #1 check({tag, "_ready_after"}, W'(in_ready), W'(1'b1));
  endtask

  task automatic randomize_inputs();
    in_sel = 4'($urandom_range(0, D - 1));
    for (int l = 0; l < M; l++) in_data[l] = N'($urandom);
    case ($urandom_range(0, 5))
      0:       in_mask = '0;
      1:       in_mask = '1;
      default: in_mask = M'($urandom);
    endcase
  endtask

  task automatic write_all(int sel, logic [M-1:0] mask, logic [N-1:0] base, bit incr, string tag);
    in_valid = 1'b1;
    in_sel   = 4'(sel);
    in_mask  = mask;
    for (int l = 0; l < M; l++) in_data[l] = incr ? base + N'(l) : base;
    step({tag, "_xfer"});
    in_valid = 1'b0;
    for (int c = 0; c < M; c++) begin
      randomize_inputs();
      step(tag);
    end
  endtask

  initial begin
    pend    = 1'b0;
    elapsed = 0;
    p_sel   = 0;
    p_bc    = 1'b0;
    for (int l = 0; l < M; l++) begin
      p_data[l] = '0;
      p_mask[l] = 1'b0;
    end

    @(negedge clk);
    do_reset("rst0");
    step("idle");

    write_all(5, '1, 16'hA000, 1'b1, "single");

    write_all(3, '1, 16'h1111, 1'b0, "preload3");
    write_all(3, 16'h00FF, 16'h2222, 1'b0, "masked3");

    write_all(7, '0, 16'h5555, 1'b0, "zeromask");

    in_valid = 1'b1;
    in_sel   = 4'd0;
    in_mask  = '1;
    for (int l = 0; l < M; l++) in_data[l] = N'($urandom);
    step("bp_xfer0");
    in_sel = 4'd15;
    for (int l = 0; l < M; l++) in_data[l] = N'($urandom);
    repeat (M + 1) step("bp");
    in_valid = 1'b0;
    repeat (M) step("bp_second");

    in_valid = 1'b1;
    in_sel   = 4'd9;
    in_mask  = '1;
    for (int l = 0; l < M; l++) in_data[l] = 16'hC000 + N'(l);
    step("abort_xfer");
    in_valid = 1'b0;
    repeat (7) step("abort");
    do_reset("abort_rst");
    repeat (M + 2) step("abort_after");

`ifdef VEC_DEMUX_BCAST_EN
    in_bcast = 1'b1;
    write_all(2, '1, 16'hBEEF, 1'b0, "bcast");
    in_bcast = 1'b0;
    write_all(4, 16'hF0F0, 16'h1234, 1'b0, "post_bcast");
`endif

    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      randomize_inputs();
`ifdef VEC_DEMUX_BCAST_EN
      in_bcast = ($urandom_range(0, 7) == 0);
`endif
      if (c == 311) do_reset("rand_rst");
      step("rand");
    end
    in_valid = 1'b0;
    repeat (M + 1) step("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_demux_1_16.md
VEC_DEMUX_1_16 -- requirements
Module: vec_demux_1_16

Interface
REQ-001 SHALL have parameter N, default 16, lane width in bits.
REQ-002 SHALL have parameter M, default 16, lanes per vector.
REQ-003 SHALL have one clock and one reset: clk, rising-edge; rst_n, asynchronous, active-low.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  source presents a write request.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_data  input  [M-1:0][N-1:0]  vector to write.
REQ-009 in_sel  input  4  destination register index, 0..15.
REQ-010 in_mask  input  M  per-lane write enable, 1 = write lane.
REQ-011 out_reg  output  [15:0][M-1:0][N-1:0]  the 16 destination vectors, sized to feed the 16:1 vector read mux.
REQ-012 out_done  output  16  one-cycle pulse on bit in_sel when that destination's write completes.
REQ-013 busy  output  1  high while a write is in progress.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-015 in_ready SHALL equal (state == IDLE); a transfer occurs when in_valid && in_ready.
REQ-016 On transfer, SHALL capture in_data, in_sel, in_mask into holding registers, clear lane counter to 0, go to WRITE.
REQ-017 In WRITE, SHALL update exactly one lane per cycle: lane = counter of register sel, only if mask[counter] = 1; masked-off lanes keep their value but still consume one cycle.
REQ-018 Counter SHALL increment by 1 per WRITE cycle; at counter == M-1, SHALL write that lane, pulse out_done[sel] that same cycle, and return to IDLE.
REQ-019 Latency: transfer at edge t; lane k written at edge t+1+k; out_done high during cycle t+M; next transfer possible at edge t+M+1.
REQ-020 in_data/in_sel/in_mask changes while busy SHALL have no effect.
REQ-021 Registers other than sel SHALL never change during a write.
REQ-022 Counter width SHALL be $clog2(M), minimum 1; no wrap beyond M-1.
REQ-023 All-zero mask SHALL still take M cycles and pulse out_done, with no register change.
REQ-024 busy SHALL equal (state == WRITE); out_done SHALL be zero in IDLE.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, holding registers 0, out_reg all 0, out_done 0, busy 0, in_ready 1 after release.
REQ-026 Reset mid-write SHALL abandon the write; lanes already written are cleared with all other registers, and no out_done pulse SHALL occur.

Configuration
REQ-027 Macro VEC_DEMUX_BCAST_EN SHALL gate broadcast support.
REQ-028 Defined: extra input in_bcast (1 bit, captured on transfer); when set, each WRITE cycle SHALL write the lane into all 16 registers and out_done SHALL pulse all 16 bits at completion.
REQ-029 Undefined: no in_bcast port; only register in_sel is written.

Structure
REQ-030 Shared package vec_pkg SHALL hold the FSM state enum, the destination count constant (16), and the select width constant (4).
REQ-031 Lane counter with terminal-count flag SHALL be a sub-module vec_lane_counter; the register array, FSM, and decode stay in vec_demux_1_16.

Verification
REQ-032 Reset: assert rst_n=0 mid-run -> out_reg all 0, busy 0, in_ready 1 after release.
REQ-033 Single write, N=M=16: sel=5, data lane i = 16'hA000+i, mask=16'hFFFF -> out_reg[5] lane i = 16'hA000+i after 16 WRITE cycles, out_done = 16'h0020 during cycle t+16, others unchanged.
REQ-034 Masked write: preload reg 3 with 16'h1111 per lane, then sel=3, data 16'h2222, mask=16'h00FF -> lanes 0..7 = 16'h2222, lanes 8..15 = 16'h1111.
REQ-035 Back-pressure: hold in_valid high with sel 0 then sel 15 -> in_ready low for 16 cycles, second request accepted at edge t+17, both registers correct.
REQ-036 Reset at counter=7 of a write to sel=9 -> no out_done pulse, out_reg[9] all 0.
REQ-037 With VEC_DEMUX_BCAST_EN: in_bcast=1, data 16'hBEEF all lanes -> all 16 registers equal 16'hBEEF per lane, out_done = 16'hFFFF for one cycle.
